// File: rtl/clk_div_monitor.sv
// Period/duty checker for a divided clock sampled as data in the clk_i domain.
// Tracks lock over a run of good periods; flags bad periods while locked and stalls.
module clk_div_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 16,
  parameter int CW         = 8
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          div_clk_i,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          period_vld_o,
  output logic          locked_o,
  output logic          err_o,
  output logic [7:0]    err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_e;

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] EXP_P = CW'(EXP_PERIOD);
  localparam logic [CW-1:0] EXP_H = CW'(EXP_PERIOD / 2);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sdly_q, sdly_d;
  logic [1:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          vld_q, vld_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [GW-1:0] good_q, good_d;

  logic primed;
  logic rise;
  logic fall;
  logic good;
  logic stall;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sdly_q    <= 1'b0;
      fill_q    <= 2'd0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      good_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sdly_q    <= sdly_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      vld_q     <= vld_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      good_q    <= good_d;
    end
  end

  // Edges count only once the delay flop holds a real sample, so a clock
  // stuck high through reset is not mistaken for a rise.
  always_comb begin
    sync1_d = div_clk_i;
    sync2_d = sync1_q;
    sdly_d  = sync2_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    primed  = (fill_q == 2'd3);
    rise    = primed & sync2_q & ~sdly_q;
    fall    = primed & ~sync2_q & sdly_q;

    if (rise) begin
      cnt_d  = CW'(1);
      hcnt_d = CW'(1);
    end else begin
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      hcnt_d = (sync2_q && hcnt_q != CNT_MAX) ? hcnt_q + CW'(1) : hcnt_q;
    end
    high_d = fall ? hcnt_q : high_q;

    good  = (cnt_q == EXP_P) && (high_q == EXP_H);
    stall = (cnt_q == TMO) && !rise;
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    period_d = period_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (!good) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else if (stall) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (!good) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = ACQ;
          end
        end else if (stall) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign period_vld_o = vld_q;
  assign locked_o     = locked_q;
  assign err_o        = err_q;
  assign err_cnt_o    = err_cnt_q;

endmodule
